// File: rtl/bf16_pkg.sv
// ============================================================================
// Module : bf16_pkg
// Brief  : Shared bfloat16 field layout, constants and divider FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bf16_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 7;
  localparam int WORD_W = 1 + EXP_W + MAN_W;

  localparam int                 BF16_BIAS = 127;
  localparam logic [WORD_W-1:0]  BF16_QNAN = 16'h7FC0;
  localparam logic [EXP_W-1:0]   EXP_MAX   = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } bf16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bf16_classify.sv
// ============================================================================
// Module : bf16_classify
// Brief  : Combinational zero/inf/NaN classification of one bfloat16 operand.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bf16_classify
  import bf16_pkg::*;
(
  input  bf16_t i_op,
  output logic  o_is_zero,
  output logic  o_is_inf,
  output logic  o_is_nan
);

  // Zero exponent covers denormals too: they are flushed to zero.
  assign o_is_zero = (i_op.exp == '0);
  assign o_is_inf  = (i_op.exp == EXP_MAX) && (i_op.man == '0);
  assign o_is_nan  = (i_op.exp == EXP_MAX) && (i_op.man != '0);

endmodule

`default_nettype wire

// File: rtl/bf16_divider.sv
// ============================================================================
// Module : bf16_divider
// Brief  : Sequential bfloat16 divider, restoring division one bit per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bf16_divider
  import bf16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] quo,
  output logic              dbz
);

  state_e r_state, w_state_nxt;

  bf16_t w_a, w_b;
  logic  w_a_zero, w_a_inf, w_a_nan;
  logic  w_b_zero, w_b_inf, w_b_nan;
  logic  w_sign;

  logic                    w_special;
  logic [WORD_W-1:0]       w_spec_quo;
  logic                    w_spec_dbz;
  logic signed [9:0]       w_e_cap;

  logic                    r_sign;
  logic signed [9:0]       r_exp;
  logic [MAN_W+1:0]        r_rem;
  logic [MAN_W:0]          r_mb;
  logic [MAN_W+1:0]        r_q;
  logic [3:0]              r_count;
  logic                    r_special;
  logic [WORD_W-1:0]       r_spec_quo;
  logic                    r_spec_dbz;
  logic [WORD_W-1:0]       r_quo;
  logic                    r_dbz;
  logic                    r_out_valid;

  logic                    w_ge;
  logic [MAN_W+1:0]        w_diff;
  logic signed [9:0]       w_exp_n;
  logic [MAN_W-1:0]        w_man;
  logic [WORD_W-1:0]       w_norm_quo;

  assign w_a    = a;
  assign w_b    = b;
  assign w_sign = w_a.sign ^ w_b.sign;

  bf16_classify u_cls_a (
    .i_op      (w_a),
    .o_is_zero (w_a_zero),
    .o_is_inf  (w_a_inf),
    .o_is_nan  (w_a_nan)
  );

  bf16_classify u_cls_b (
    .i_op      (w_b),
    .o_is_zero (w_b_zero),
    .o_is_inf  (w_b_inf),
    .o_is_nan  (w_b_nan)
  );

  assign w_e_cap = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                 + $signed(10'(BF16_BIAS));

  // Special results are fixed at capture; the divide still runs for constant latency.
  always_comb begin
    w_special  = 1'b1;
    w_spec_quo = BF16_QNAN;
    w_spec_dbz = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_quo = BF16_QNAN;
    end else if (w_b_zero) begin
      w_spec_quo = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_spec_dbz = !w_a_inf;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_quo = {w_sign, {(WORD_W-1){1'b0}}};
    end else if (w_a_inf) begin
      w_spec_quo = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      w_special  = 1'b0;
    end
  end

  assign w_ge   = (r_rem >= {1'b0, r_mb});
  assign w_diff = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  assign w_exp_n = r_q[MAN_W+1] ? r_exp : (r_exp - 10'sd1);
  assign w_man   = r_q[MAN_W+1] ? r_q[MAN_W:1] : r_q[MAN_W-1:0];

  always_comb begin
    w_norm_quo = {r_sign, w_exp_n[EXP_W-1:0], w_man};
    if (w_exp_n >= 10'sd255) begin
      w_norm_quo = {r_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (w_exp_n <= 10'sd0) begin
      w_norm_quo = {r_sign, {(WORD_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = DIV;
      DIV:     if (r_count == 4'(MAN_W + 1)) w_state_nxt = NORM;
      NORM:    w_state_nxt = DONE;
      DONE:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_mb        <= '0;
      r_q         <= '0;
      r_count     <= '0;
      r_special   <= 1'b0;
      r_spec_quo  <= '0;
      r_spec_dbz  <= 1'b0;
      r_quo       <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign     <= w_sign;
            r_exp      <= w_e_cap;
            r_rem      <= {1'b0, 1'b1, w_a.man};
            r_mb       <= {1'b1, w_b.man};
            r_q        <= '0;
            r_count    <= '0;
            r_special  <= w_special;
            r_spec_quo <= w_spec_quo;
            r_spec_dbz <= w_spec_dbz;
          end
        end
        DIV: begin
          r_q     <= {r_q[MAN_W:0], w_ge};
          r_rem   <= w_diff << 1;
          r_count <= r_count + 4'd1;
        end
        NORM: begin
          r_quo <= r_special ? r_spec_quo : w_norm_quo;
          r_dbz <= r_special & r_spec_dbz;
        end
        DONE: begin
          // out_valid rises one cycle after DONE entry and drops on transfer.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign quo       = r_quo;
  assign dbz       = r_dbz;

endmodule

`default_nettype wire
